// File: rtl/vm_pkg.sv
// Shared types and coin constants for the multi-product vending controller.
package vm_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, SERVE, CHANGE} vm_state_e;

  typedef enum logic [1:0] {COIN_N, COIN_D, COIN_Q} vm_coin_e;

  localparam logic [2:0] VAL_NICKEL  = 3'd1;
  localparam logic [2:0] VAL_DIME    = 3'd2;
  localparam logic [2:0] VAL_QUARTER = 3'd5;

  function automatic logic [2:0] coin_value(input vm_coin_e c);
    case (c)
      COIN_Q:  return VAL_QUARTER;
      COIN_D:  return VAL_DIME;
      default: return VAL_NICKEL;
    endcase
  endfunction

endpackage

// File: rtl/vm_credit_datapath.sv
// Credit register with coin add, price subtract, overflow/affordability checks
// and largest-first change coin selection.
module vm_credit_datapath
  import vm_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   coin_val,
  input  logic         add,
  input  logic         buy,
  input  logic         change_ack,
  input  logic [N-1:0] price,
  output logic [N-1:0] credit,
  output logic         enough,
  output logic         zero,
  output logic         ovf,
  output logic         last,
  output vm_coin_e     chg_coin
);

  logic [N:0]   sum;
  logic [N-1:0] cr_new;
  logic [N-1:0] chg_val;

  // Purchases are judged against the credit after this cycle's coin.
  assign sum    = {1'b0, credit} + {{(N-2){1'b0}}, coin_val};
  assign ovf    = sum[N];
  assign cr_new = ovf ? credit : sum[N-1:0];
  assign enough = (price <= cr_new);
  assign zero   = (credit == '0);

  always_comb begin
    if (credit >= N'(VAL_QUARTER))   chg_coin = COIN_Q;
    else if (credit >= N'(VAL_DIME)) chg_coin = COIN_D;
    else                             chg_coin = COIN_N;
  end

  assign chg_val = N'(coin_value(chg_coin));
  assign last    = (credit == chg_val);

  always_ff @(posedge clk) begin
    if (!rst)            credit <= '0;
    else if (change_ack) credit <= credit - chg_val;
    else if (buy)        credit <= cr_new - price;
    else if (add)        credit <= cr_new;
  end

endmodule

// File: rtl/multi_vending_machine.sv
// Multi-product vending controller: coin collection, priced vend, coin-by-coin change.
// Optional VM_CANCEL_EN adds a cancel input that refunds all credit from COLLECT.
module multi_vending_machine
  import vm_pkg::*;
#(
  parameter int unsigned N     = 6,
  parameter int unsigned NPROD = 4,
  parameter int unsigned SW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nickel,
  input  logic               dime,
  input  logic               quarter,
  input  logic [SW-1:0]      sel,
  input  logic               dispense,
  input  logic [N*NPROD-1:0] prices,
  input  logic [NPROD-1:0]   sold_out,
  input  logic               done,
`ifdef VM_CANCEL_EN
  input  logic               cancel,
`endif
  output logic               serve,
  output logic [SW-1:0]      served_id,
  output logic               change_q,
  output logic               change_d,
  output logic               change_n,
  output logic               deny,
  output logic               coin_reject,
  output logic [N-1:0]       credit
);

  vm_state_e state, next_state;
  vm_coin_e  chg_coin;

  logic         cancel_w;
  logic         accepting, multi, any_coin;
  logic [2:0]   coin_val;
  logic [N-1:0] price_sel;
  logic         sold_sel, sel_valid;
  logic         enough, zero, ovf, last;
  logic         add, buy, change_ack, deny_d, reject_d;

`ifdef VM_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign accepting = (state == IDLE) || (state == COLLECT);
  assign any_coin  = nickel | dime | quarter;
  assign multi     = (nickel & dime) | (nickel & quarter) | (dime & quarter);

  always_comb begin
    coin_val = '0;
    if (accepting && !multi) begin
      if (quarter)     coin_val = VAL_QUARTER;
      else if (dime)   coin_val = VAL_DIME;
      else if (nickel) coin_val = VAL_NICKEL;
    end
  end

  // Out-of-range selections match no entry and are refused via sel_valid.
  always_comb begin
    price_sel = '0;
    sold_sel  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NPROD; i++) begin
      if (32'(sel) == i) begin
        price_sel = prices[i*N +: N];
        sold_sel  = sold_out[i];
        sel_valid = 1'b1;
      end
    end
  end

  vm_credit_datapath #(.N(N)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .coin_val   (coin_val),
    .add        (add),
    .buy        (buy),
    .change_ack (change_ack),
    .price      (price_sel),
    .credit     (credit),
    .enough     (enough),
    .zero       (zero),
    .ovf        (ovf),
    .last       (last),
    .chg_coin   (chg_coin)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      served_id   <= '0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= next_state;
      deny        <= deny_d;
      coin_reject <= reject_d;
      if (buy) served_id <= sel;
    end
  end

  always_comb begin
    next_state = state;
    add        = 1'b0;
    buy        = 1'b0;
    change_ack = 1'b0;
    deny_d     = 1'b0;
    reject_d   = any_coin && (!accepting || multi || ovf);
    case (state)
      IDLE, COLLECT: begin
        add = 1'b1;
        if (coin_val != '0 && !ovf) next_state = COLLECT;
        if (cancel_w && state == COLLECT) begin
          next_state = CHANGE;
        end else if (dispense) begin
          if (sel_valid && !sold_sel && enough) begin
            buy        = 1'b1;
            next_state = SERVE;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (done) next_state = zero ? IDLE : CHANGE;
      end
      CHANGE: begin
        if (done) begin
          change_ack = 1'b1;
          if (last) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    serve    = (state == SERVE);
    change_q = (state == CHANGE) && (chg_coin == COIN_Q);
    change_d = (state == CHANGE) && (chg_coin == COIN_D);
    change_n = (state == CHANGE) && (chg_coin == COIN_N);
  end

endmodule

// File: doc/multi_vending_machine.md
# multi_vending_machine

Parametrised next-generation vending controller. It accepts nickel, dime and quarter coins and sells any of `NPROD` products with individually programmed prices and sold-out flags. After a sale it returns change coin by coin in quarters, dimes and nickels, largest coin first, with a `done` handshake on every output event. It sits between the coin mechanism and selection panel on one side and the product and coin dispensers on the other.

## Interface
- `N`, 6: credit and price width, in nickel units (credit range 0..2^N-1 nickels).
- `NPROD`, 4: number of products, at least 2.
- `SW`, 2: selection index width, equal to clog2(NPROD).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `nickel`, `dime`, `quarter` input 1 each: one-cycle coin pulses worth 1, 2 and 5 nickels.
- `sel` input SW: product index, sampled while `dispense` is high.
- `dispense` input 1: one-cycle purchase request.
- `prices` input N*NPROD: flattened price table; product i occupies bits [i*N +: N]; unit is nickels.
- `sold_out` input NPROD: bit i high means product i is unavailable.
- `done` input 1: acknowledges the current `serve` or change-coin output.
- `serve` output 1: level; product dispense in progress.
- `served_id` output SW: index of the product being served; valid while `serve` is high.
- `change_q`, `change_d`, `change_n` output 1 each: level, one-hot; eject one quarter, dime or nickel.
- `deny` output 1: one-cycle pulse when a purchase request is refused.
- `coin_reject` output 1: one-cycle pulse when a coin is refused (the mechanism returns that coin).
- `credit` output N: current credit in nickels.

## Operation
- States:
  - IDLE: credit is 0.
  - COLLECT: credit is above 0.
  - SERVE
  - CHANGE
- Coin acceptance:
  - Coins are accepted only in IDLE and COLLECT.
  - An accepted coin adds 1, 2 or 5 to `credit`.
  - IDLE moves to COLLECT on the first accepted coin.
- Coin refusal, each case giving one `coin_reject` pulse with credit unchanged:
  - more than one coin input high in the same cycle (all of them are refused);
  - credit + value would exceed 2^N-1;
  - any coin while in SERVE or CHANGE.
- `dispense` in IDLE or COLLECT, evaluated against the index `s` = `sel`:
  - `s` >= NPROD, `sold_out[s]` high, or `prices[s]` > credit: `deny` pulse, state unchanged.
  - Otherwise: go to SERVE, `credit` becomes credit - `prices[s]`, `served_id` latches `s`.
  - A price of 0 is a valid free vend.
- SERVE:
  - `serve` stays high until `done`.
  - On `done`, go to CHANGE if credit is above 0, otherwise to IDLE.
- CHANGE:
  - The coin to eject is quarter if credit >= 5, else dime if credit >= 2, else nickel.
  - Exactly one `change_*` output is high at a time.
  - On `done`, credit drops by that coin's value. The next coin is asserted in the following cycle, or the state goes to IDLE when credit reaches 0.
- Concurrency:
  - A coin and `dispense` in the same cycle in IDLE/COLLECT: the coin is added first, then the purchase is evaluated against the new credit.
  - `dispense` in SERVE or CHANGE is ignored: no `deny`.
  - `done` outside SERVE and CHANGE is ignored.
- Reset mid-operation:
  - Credit is discarded and the state returns to IDLE.
  - Any `serve` or `change_*` output drops the cycle after reset is sampled.

## Timing
- Reset values:
  - state IDLE, `credit` = 0, `served_id` = 0;
  - `serve`, `change_q`, `change_d`, `change_n`, `deny` and `coin_reject` all 0.
- Coin pulse at edge k: `credit` shows the new value after edge k, i.e. one cycle of latency.
- `dispense` at edge k: `serve` (or `deny`) is high from edge k. `credit` already holds the post-price value.
- `done` at edge k in SERVE: `serve` is low after edge k. The first change output is high after the same edge.
- Change coins: each coin needs at least 1 cycle high and is held until `done`.
- `done` may arrive in the same cycle that an output first rises; it is accepted, giving a minimum of 1 cycle per event.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `VM_CANCEL_EN` defined:
  - adds input `cancel` (1 bit);
  - `cancel` in COLLECT goes directly to CHANGE and refunds all credit;
  - `cancel` in IDLE, SERVE or CHANGE is ignored;
  - `cancel` together with `dispense` in the same cycle: `cancel` wins, no `deny`.
- `VM_CANCEL_EN` undefined: no `cancel` port; credit is returned only as change after a purchase.

## Structure
- Package `vm_pkg`:
  - state enumeration (IDLE, COLLECT, SERVE, CHANGE);
  - coin value constants `VAL_NICKEL`=1, `VAL_DIME`=2, `VAL_QUARTER`=5.
- Sub-module `vm_credit_datapath`, parameter `N`:
  - holds the credit register, the add and subtract logic, the overflow check and the price comparison;
  - selects the change coin;
  - exports `enough`, `zero` and `ovf` to the controlling state machine.

## Test plan
- Price table with `prices[2]`=7. Quarter, then dime, then `dispense` with `sel`=2 → `serve`=1, `served_id`=2, `credit`=0. `done` → IDLE, no change outputs.
- Credit 9, buy `prices[1]`=2 → `serve`, then change sequence quarter, dime, with `done` after each. `credit` reads 7 → 2 → 0, then IDLE.
- N=6, credit 60, quarter → `coin_reject` pulse, credit stays 60. Nickel and dime in the same cycle → `coin_reject`, credit stays 60.
- `sold_out[0]`=1, credit 20, `dispense` with `sel`=0 → `deny` pulse, credit stays 20. `sel`=3 with `prices[3]`=25 → `deny`.
- Coin during SERVE → `coin_reject`. `rst`=0 during CHANGE → all outputs 0 and `credit`=0 the next cycle.
- `VM_CANCEL_EN` defined: credit 8, `cancel` → quarter, dime and nickel (5 + 2 + 1) ejected in turn, then IDLE.
